seg7_scan_ctrl: RTL and testbench
=================================

SEG7_SCAN_CTRL -- requirements
Module: seg7_scan_ctrl

Interface
REQ-001 Parameter NUM_DIG, default 8: number of multiplexed digits; legal range 2..16.
REQ-002 Parameter DIG_PER_BANK, default 4: digits 0..DIG_PER_BANK-1 drive seg_r, the remaining digits drive seg_l; legal range 1..NUM_DIG-1.
REQ-003 Parameter DIV_W, default 16: prescaler width, one digit slot lasts 2^DIV_W clk cycles; minimum PWM_W+1.
REQ-004 Parameter PWM_W, default 4: brightness resolution.
REQ-005 Parameter BLINK_W, default 6: frame counter width, blink period is 2^BLINK_W frames.
REQ-006 clk  input  1  system clock, all logic is on its rising edge.
REQ-007 rst_n  input  1  reset, asynchronous, active-low.
REQ-008 enable  input  1  scan enable.
REQ-009 frame_data  input  NUM_DIG*8  segment patterns, byte k is digit k.
REQ-010 frame_valid  input  1  frame offer.
REQ-011 frame_ready  output  1  shadow buffer empty.
REQ-012 brightness  input  PWM_W  duty level, 0 is dark.
REQ-013 blink_mask  input  NUM_DIG  per-digit blink enable.
REQ-014 seg_sel  output  NUM_DIG  one-hot digit select, active-high.
REQ-015 seg_r  output  8  right-bank segments, active-high.
REQ-016 seg_l  output  8  left-bank segments, active-high.
REQ-017 frame_start  output  1  one-cycle pulse when digit 0 begins a new scan.

Function
REQ-018 The prescaler shall count 0..2^DIV_W-1 and wrap; the cycle in which it is at terminal count shall be a tick.
REQ-019 On a tick, the digit index shall advance by 1 and wrap from NUM_DIG-1 to 0; that wrap is the frame boundary.
REQ-020 A frame transfer shall complete when frame_valid and frame_ready are both high on a clk edge; frame_data is then captured into the shadow buffer and frame_ready drops on the next cycle.
REQ-021 At a frame boundary with the shadow buffer full, the shadow shall be copied to the active buffer and frame_ready shall rise on the next cycle; with the shadow buffer empty, the active buffer is retained.
REQ-022 A transfer can never coincide with a copy because frame_ready is low whenever the shadow buffer is full; frame_valid while frame_ready is low shall be ignored and data held by the source.
REQ-023 frame_start shall pulse high for exactly the cycle after the frame boundary, coincident with the first cycle of the digit-0 slot.
REQ-024 The frame counter (BLINK_W bits) shall increment at each frame boundary and wrap; blink phase is its MSB.
REQ-025 The current digit pattern shall be the active byte, forced to 8'h00 when the current blink_mask bit is 1 and blink phase is 1.
REQ-026 The pattern shall load into seg_r when the index is below DIG_PER_BANK, otherwise into seg_l; the other bank holds its last value.
REQ-027 seg_sel shall be one-hot on the current index while prescaler[DIV_W-1 -: PWM_W] < brightness, otherwise all zero.
REQ-028 Brightness 2^PWM_W-1 shall give a duty of (2^PWM_W-1)/2^PWM_W, and brightness 0 shall give seg_sel permanently zero.
REQ-029 All outputs shall be registered with one cycle latency from the index/prescaler state.
REQ-030 While enable is low: prescaler, index and frame counter clear to 0; seg_sel is all zero; the handshake and the shadow capture continue; no copy occurs.
REQ-031 Enable rising shall start at digit 0 with frame_start pulsing, and the shadow buffer, if full, shall be copied at that restart.

Reset
REQ-032 In reset: seg_sel all zero; seg_r and seg_l 8'h00; frame_ready 1; frame_start 0; both buffers, the prescaler, the index and the frame counter all cleared.
REQ-033 Reset asserted mid-frame shall discard a pending shadow frame immediately.

Structure
REQ-034 The shared display package shall hold the 7-segment glyph constants (hex digits, blank, dash) and the default parameter values.
REQ-035 There shall be one sub-module, seg7_prescaler, which generates the tick and the PWM compare slice.

Verification
REQ-036 DIV_W=5, PWM_W=4, brightness=15: seg_sel shall step 01,02,04..80 each 32 cycles, and each select shall be high for 30 of the 32 cycles.
REQ-037 Offer frame 0x0102030405060708 mid-scan: seg_r/seg_l shall still show the old frame until the boundary, then digit 0 shows 0x08 and digit 7 shows 0x01; frame_ready shall be low in between.
REQ-038 Two back-to-back offers within one frame: the second shall stall (ready low) until the boundary and be accepted one cycle after frame_ready rises.
REQ-039 BLINK_W=2, blink_mask=0x01: digit 0 shall be blank in frames 2 and 3 and shown in frames 0 and 1; other digits shall be unaffected.
REQ-040 brightness=0, and separately enable=0, shall give seg_sel==0; deasserting enable mid-frame and re-asserting shall restart at digit 0 with one frame_start pulse.
REQ-041 rst_n low for 1 cycle mid-scan with the shadow full: all outputs shall reach their reset values asynchronously, frame_ready=1, and the pending frame shall never display.

Source files
------------

// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared display constants: 7-segment glyphs and default scan parameters
package seg7_pkg;

  // Default parameter values for the scan controller
  localparam int DEF_NUM_DIG      = 8;
  localparam int DEF_DIG_PER_BANK = 4;
  localparam int DEF_DIV_W        = 16;
  localparam int DEF_PWM_W        = 4;
  localparam int DEF_BLINK_W      = 6;

  // Glyphs, bit 0 = segment a ... bit 6 = segment g, bit 7 = decimal point
  localparam logic [7:0] GLYPH_0     = 8'h3F;
  localparam logic [7:0] GLYPH_1     = 8'h06;
  localparam logic [7:0] GLYPH_2     = 8'h5B;
  localparam logic [7:0] GLYPH_3     = 8'h4F;
  localparam logic [7:0] GLYPH_4     = 8'h66;
  localparam logic [7:0] GLYPH_5     = 8'h6D;
  localparam logic [7:0] GLYPH_6     = 8'h7D;
  localparam logic [7:0] GLYPH_7     = 8'h07;
  localparam logic [7:0] GLYPH_8     = 8'h7F;
  localparam logic [7:0] GLYPH_9     = 8'h6F;
  localparam logic [7:0] GLYPH_A     = 8'h77;
  localparam logic [7:0] GLYPH_B     = 8'h7C;
  localparam logic [7:0] GLYPH_C     = 8'h39;
  localparam logic [7:0] GLYPH_D     = 8'h5E;
  localparam logic [7:0] GLYPH_E     = 8'h79;
  localparam logic [7:0] GLYPH_F     = 8'h71;
  localparam logic [7:0] GLYPH_BLANK = 8'h00;
  localparam logic [7:0] GLYPH_DASH  = 8'h40;

  // Codes 0..15 map to hex digits, 16 is blank, anything else is a dash
  function automatic logic [7:0] glyph(input logic [4:0] code);
    logic [7:0] g;
    case (code)
      5'd0:    g = GLYPH_0;
      5'd1:    g = GLYPH_1;
      5'd2:    g = GLYPH_2;
      5'd3:    g = GLYPH_3;
      5'd4:    g = GLYPH_4;
      5'd5:    g = GLYPH_5;
      5'd6:    g = GLYPH_6;
      5'd7:    g = GLYPH_7;
      5'd8:    g = GLYPH_8;
      5'd9:    g = GLYPH_9;
      5'd10:   g = GLYPH_A;
      5'd11:   g = GLYPH_B;
      5'd12:   g = GLYPH_C;
      5'd13:   g = GLYPH_D;
      5'd14:   g = GLYPH_E;
      5'd15:   g = GLYPH_F;
      5'd16:   g = GLYPH_BLANK;
      default: g = GLYPH_DASH;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/seg7_prescaler.sv
// rtl/seg7_prescaler.sv - digit slot prescaler producing the slot tick and PWM compare slice
module seg7_prescaler
  import seg7_pkg::*;
#(
  parameter int DIV_W = DEF_DIV_W,
  parameter int PWM_W = DEF_PWM_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  output logic             tick,
  output logic [PWM_W-1:0] pwm_slice
);

  logic [DIV_W-1:0] cnt_q;
  logic [DIV_W-1:0] cnt_d;

  // Free-running slot counter, held at zero while the scan is stopped
  always_comb begin
    cnt_d = cnt_q;
    if (!run) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + DIV_W'(1);
    end
  end

  // Counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Terminal count ends the slot; the top bits ramp through the PWM period once per slot
  assign tick      = run && (&cnt_q);
  assign pwm_slice = cnt_q[DIV_W-1 -: PWM_W];

endmodule

// File: rtl/seg7_scan_ctrl.sv
// rtl/seg7_scan_ctrl.sv - multiplexed 7-segment scan controller with double-buffered frames
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int NUM_DIG      = DEF_NUM_DIG,
  parameter int DIG_PER_BANK = DEF_DIG_PER_BANK,
  parameter int DIV_W        = DEF_DIV_W,
  parameter int PWM_W        = DEF_PWM_W,
  parameter int BLINK_W      = DEF_BLINK_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic [NUM_DIG*8-1:0] frame_data,
  input  logic                 frame_valid,
  output logic                 frame_ready,
  input  logic [PWM_W-1:0]     brightness,
  input  logic [NUM_DIG-1:0]   blink_mask,
  output logic [NUM_DIG-1:0]   seg_sel,
  output logic [7:0]           seg_r,
  output logic [7:0]           seg_l,
  output logic                 frame_start
);

  localparam int IDX_W = (NUM_DIG > 1) ? $clog2(NUM_DIG) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_DIG - 1);
  localparam logic [IDX_W-1:0] BANK_SPLIT = IDX_W'(DIG_PER_BANK);

  logic                 enable_q, enable_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [BLINK_W-1:0]   fcnt_q, fcnt_d;
  logic [NUM_DIG*8-1:0] shadow_q, shadow_d;
  logic [NUM_DIG*8-1:0] active_q, active_d;
  logic                 frame_ready_q, frame_ready_d;
  logic [NUM_DIG-1:0]   seg_sel_q, seg_sel_d;
  logic [7:0]           seg_r_q, seg_r_d;
  logic [7:0]           seg_l_q, seg_l_d;
  logic                 frame_start_q, frame_start_d;

  logic             tick;
  logic [PWM_W-1:0] pwm_slice;
  logic             run;
  logic             restart;
  logic             wrap;
  logic             boundary;
  logic             copy;
  logic             accept;
  logic [7:0]       cur_pat;

  // The cycle enable rises is a restart: counters stay at zero for it, so the
  // first running cycle is digit 0 / count 0, exactly like after a normal wrap.
  assign run      = enable && enable_q;
  assign restart  = enable && !enable_q;
  assign wrap     = tick && (idx_q == LAST_IDX);
  assign boundary = wrap || restart;
  assign copy     = boundary && !frame_ready_q;
  assign accept   = frame_valid && frame_ready_q;

  seg7_prescaler #(
    .DIV_W(DIV_W),
    .PWM_W(PWM_W)
  ) u_prescaler (
    .clk      (clk),
    .rst_n    (rst_n),
    .run      (run),
    .tick     (tick),
    .pwm_slice(pwm_slice)
  );

  // Next-state for scan position, frame buffers, handshake and registered outputs
  always_comb begin
    enable_d      = enable;
    idx_d         = idx_q;
    fcnt_d        = fcnt_q;
    shadow_d      = shadow_q;
    active_d      = active_q;
    frame_ready_d = frame_ready_q;
    seg_sel_d     = '0;
    seg_r_d       = seg_r_q;
    seg_l_d       = seg_l_q;
    frame_start_d = boundary;
    cur_pat       = active_q[{idx_q, 3'b000} +: 8];

    if (!run) begin
      idx_d = '0;
    end else if (tick) begin
      idx_d = wrap ? '0 : idx_q + IDX_W'(1);
    end

    if (!enable) begin
      fcnt_d = '0;
    end else if (wrap) begin
      fcnt_d = fcnt_q + BLINK_W'(1);
    end

    // frame_ready low means shadow full, so accept and copy never coincide
    if (accept) begin
      shadow_d      = frame_data;
      frame_ready_d = 1'b0;
    end
    if (copy) begin
      active_d      = shadow_q;
      frame_ready_d = 1'b1;
    end

    if (blink_mask[idx_q] && fcnt_q[BLINK_W-1]) begin
      cur_pat = 8'h00;
    end

    if (run) begin
      if (pwm_slice < brightness) begin
        seg_sel_d = NUM_DIG'(1) << idx_q;
      end
      if (idx_q < BANK_SPLIT) begin
        seg_r_d = cur_pat;
      end else begin
        seg_l_d = cur_pat;
      end
    end
  end

  // State and output registers; reset also drops any pending shadow frame
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      enable_q      <= 1'b0;
      idx_q         <= '0;
      fcnt_q        <= '0;
      shadow_q      <= '0;
      active_q      <= '0;
      frame_ready_q <= 1'b1;
      seg_sel_q     <= '0;
      seg_r_q       <= 8'h00;
      seg_l_q       <= 8'h00;
      frame_start_q <= 1'b0;
    end else begin
      enable_q      <= enable_d;
      idx_q         <= idx_d;
      fcnt_q        <= fcnt_d;
      shadow_q      <= shadow_d;
      active_q      <= active_d;
      frame_ready_q <= frame_ready_d;
      seg_sel_q     <= seg_sel_d;
      seg_r_q       <= seg_r_d;
      seg_l_q       <= seg_l_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign frame_ready = frame_ready_q;
  assign seg_sel     = seg_sel_q;
  assign seg_r       = seg_r_q;
  assign seg_l       = seg_l_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// tb/tb_seg7_scan_ctrl.sv - self-checking bench for seg7_scan_ctrl with a per-digit pattern scoreboard
module tb_seg7_scan_ctrl;
  import seg7_pkg::*;

  localparam int NUM_DIG      = 8;
  localparam int DIG_PER_BANK = 4;
  localparam int DIV_W        = 5;
  localparam int PWM_W        = 4;
  localparam int BLINK_W      = 2;
  localparam int SLOT         = 32;
  localparam int FRAME        = SLOT * NUM_DIG;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 enable;
  logic [NUM_DIG*8-1:0] frame_data;
  logic                 frame_valid;
  logic                 frame_ready;
  logic [PWM_W-1:0]     brightness;
  logic [NUM_DIG-1:0]   blink_mask;
  logic [NUM_DIG-1:0]   seg_sel;
  logic [7:0]           seg_r;
  logic [7:0]           seg_l;
  logic                 frame_start;

  int         tests = 0;
  int         fails = 0;
  logic [7:0] exp_q[$];
  logic [63:0] disp     = '0;
  logic [63:0] queued   = '0;
  logic        queued_v = 1'b0;
  logic        b_pending = 1'b0;
  int          fnum = 0;

  seg7_scan_ctrl #(
    .NUM_DIG     (NUM_DIG),
    .DIG_PER_BANK(DIG_PER_BANK),
    .DIV_W       (DIV_W),
    .PWM_W       (PWM_W),
    .BLINK_W     (BLINK_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .frame_data (frame_data),
    .frame_valid(frame_valid),
    .frame_ready(frame_ready),
    .brightness (brightness),
    .blink_mask (blink_mask),
    .seg_sel    (seg_sel),
    .seg_r      (seg_r),
    .seg_l      (seg_l),
    .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(negedge clk);
  endtask

  function automatic logic [63:0] glyph_frame(input int base);
    logic [63:0] f;
    f = '0;
    for (int d = 0; d < NUM_DIG; d++) f[d*8 +: 8] = glyph(5'(base + d));
    return f;
  endfunction

  task automatic push_frame(input logic [63:0] data, input int fn);
    logic [7:0] b;
    for (int d = 0; d < NUM_DIG; d++) begin
      b = data[d*8 +: 8];
      if (blink_mask[d] && ((fn % 4) >= 2)) b = 8'h00;
      exp_q.push_back(b);
    end
  endtask

  task automatic wait_frame_start(input int maxc);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < maxc && !seen; i++) begin
      step();
      if (frame_start === 1'b1) seen = 1'b1;
    end
    tests++;
    if (!seen) begin
      fails++;
      $display("FAIL wait_frame_start: frame_start=%b, required 1 within %0d cycles", frame_start, maxc);
    end
  endtask

  // Called at the cycle frame_start is seen; returns at the next frame_start cycle.
  task automatic run_frame(input int offer_k, input logic [63:0] da, input logic hold_b, input logic [63:0] db);
    int         hi [NUM_DIG];
    logic [7:0] obs [NUM_DIG];
    logic [7:0] exp_sel;
    logic [7:0] exp_b;
    int         bad_sel;
    int         bad_fs;
    int         d;
    int         p;
    bad_sel = 0;
    bad_fs  = 0;
    for (int i = 0; i < NUM_DIG; i++) begin
      hi[i]  = 0;
      obs[i] = 8'h00;
    end
    push_frame(disp, fnum);
    for (int k = 1; k <= FRAME; k++) begin
      step();
      d = (k - 1) / SLOT;
      p = (k - 1) % SLOT;
      if (k == 1 && b_pending) begin
        tests++;
        if (frame_ready !== 1'b0) begin
          fails++;
          $display("FAIL b2b_second_accept: frame_ready=%b, required 0", frame_ready);
        end
        frame_valid = 1'b0;
        b_pending   = 1'b0;
      end
      exp_sel = ((p / 2) < int'(brightness)) ? (8'h01 << d) : 8'h00;
      if (seg_sel !== exp_sel) bad_sel++;
      if (seg_sel === (8'h01 << d)) hi[d]++;
      if (frame_start !== (k == FRAME)) bad_fs++;
      if (p == 16) obs[d] = (d < DIG_PER_BANK) ? seg_r : seg_l;
      if (offer_k > 0 && k == offer_k + 1) begin
        tests++;
        if (frame_ready !== 1'b0) begin
          fails++;
          $display("FAIL offer_accept: frame_ready=%b, required 0", frame_ready);
        end
        if (hold_b) frame_data = db;
        else frame_valid = 1'b0;
      end
      if (offer_k > 0 && k == FRAME - 1) begin
        tests++;
        if (frame_ready !== 1'b0) begin
          fails++;
          $display("FAIL ready_low_until_boundary: frame_ready=%b, required 0", frame_ready);
        end
      end
      if (offer_k > 0 && k == FRAME) begin
        tests++;
        if (frame_ready !== 1'b1) begin
          fails++;
          $display("FAIL ready_rise_at_boundary: frame_ready=%b, required 1", frame_ready);
        end
      end
      if (k == offer_k) begin
        frame_valid = 1'b1;
        frame_data  = da;
      end
    end
    tests++;
    if (bad_sel != 0) begin
      fails++;
      $display("FAIL seg_sel_scan frame %0d: %0d cycles wrong, required 0", fnum, bad_sel);
    end
    tests++;
    if (bad_fs != 0) begin
      fails++;
      $display("FAIL frame_start_pulse frame %0d: %0d cycles wrong, required 0", fnum, bad_fs);
    end
    for (int i = 0; i < NUM_DIG; i++) begin
      tests++;
      if (hi[i] != 2 * int'(brightness)) begin
        fails++;
        $display("FAIL seg_sel_duty frame %0d digit %0d: high %0d cycles, required %0d", fnum, i, hi[i], 2 * int'(brightness));
      end
    end
    for (int i = 0; i < NUM_DIG; i++) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL seg_pattern frame %0d digit %0d: scoreboard empty", fnum, i);
      end else begin
        exp_b = exp_q.pop_front();
        if (obs[i] !== exp_b) begin
          fails++;
          $display("FAIL seg_pattern frame %0d digit %0d: got %h, required %h", fnum, i, obs[i], exp_b);
        end
      end
    end
    fnum++;
    if (queued_v) begin
      disp     = queued;
      queued_v = 1'b0;
    end else if (offer_k > 0) begin
      disp = da;
    end
    if (hold_b) begin
      queued    = db;
      queued_v  = 1'b1;
      b_pending = 1'b1;
    end
  endtask

  task automatic test_reset();
    step();
    step();
    tests++;
    if (seg_sel !== 8'h00) begin fails++; $display("FAIL reset_seg_sel: got %h, required 00", seg_sel); end
    tests++;
    if (seg_r !== 8'h00) begin fails++; $display("FAIL reset_seg_r: got %h, required 00", seg_r); end
    tests++;
    if (seg_l !== 8'h00) begin fails++; $display("FAIL reset_seg_l: got %h, required 00", seg_l); end
    tests++;
    if (frame_ready !== 1'b1) begin fails++; $display("FAIL reset_frame_ready: got %b, required 1", frame_ready); end
    tests++;
    if (frame_start !== 1'b0) begin fails++; $display("FAIL reset_frame_start: got %b, required 0", frame_start); end
    rst_n = 1'b1;
    step();
    step();
    tests++;
    if (seg_sel !== 8'h00 || frame_ready !== 1'b1) begin
      fails++;
      $display("FAIL idle_after_reset: seg_sel=%h frame_ready=%b, required 00 and 1", seg_sel, frame_ready);
    end
  endtask

  task automatic test_scan();
    frame_data  = glyph_frame(0);
    frame_valid = 1'b1;
    step();
    frame_valid = 1'b0;
    tests++;
    if (frame_ready !== 1'b0) begin fails++; $display("FAIL capture_while_disabled: frame_ready=%b, required 0", frame_ready); end
    enable = 1'b1;
    wait_frame_start(4);
    tests++;
    if (frame_ready !== 1'b1) begin fails++; $display("FAIL copy_at_restart: frame_ready=%b, required 1", frame_ready); end
    disp = glyph_frame(0);
    fnum = 0;
    run_frame(-1, '0, 1'b0, '0);
  endtask

  task automatic test_update();
    run_frame(100, 64'h0102030405060708, 1'b0, '0);
    run_frame(-1, '0, 1'b0, '0);
  endtask

  task automatic test_back_to_back();
    run_frame(40, glyph_frame(8), 1'b1, {8{GLYPH_DASH}});
    run_frame(-1, '0, 1'b0, '0);
    run_frame(-1, '0, 1'b0, '0);
  endtask

  task automatic test_blink();
    blink_mask = 8'h01;
    for (int f = 0; f < 4; f++) run_frame(-1, '0, 1'b0, '0);
    blink_mask = 8'h00;
  endtask

  task automatic test_enable();
    int bad;
    brightness = 4'd0;
    run_frame(-1, '0, 1'b0, '0);
    brightness = 4'd15;
    for (int i = 0; i < 50; i++) step();
    enable = 1'b0;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (seg_sel !== 8'h00 || frame_start !== 1'b0) bad++;
      if (i == 5) begin
        frame_data  = glyph_frame(3);
        frame_valid = 1'b1;
      end
      if (i == 6) frame_valid = 1'b0;
    end
    tests++;
    if (bad != 0) begin fails++; $display("FAIL disabled_outputs: %0d cycles with seg_sel/frame_start active, required 0", bad); end
    tests++;
    if (frame_ready !== 1'b0) begin fails++; $display("FAIL no_copy_while_disabled: frame_ready=%b, required 0", frame_ready); end
    enable = 1'b1;
    step();
    tests++;
    if (frame_start !== 1'b1) begin fails++; $display("FAIL restart_frame_start: got %b, required 1", frame_start); end
    tests++;
    if (frame_ready !== 1'b1) begin fails++; $display("FAIL restart_copy: frame_ready=%b, required 1", frame_ready); end
    disp = glyph_frame(3);
    fnum = 0;
    run_frame(-1, '0, 1'b0, '0);
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 60; i++) step();
    frame_data  = 64'hFFFF_FFFF_FFFF_FFFF;
    frame_valid = 1'b1;
    step();
    frame_valid = 1'b0;
    tests++;
    if (frame_ready !== 1'b0) begin fails++; $display("FAIL mid_offer_accept: frame_ready=%b, required 0", frame_ready); end
    for (int i = 0; i < 20; i++) step();
    rst_n = 1'b0;
    #1;
    tests++;
    if (seg_sel !== 8'h00 || seg_r !== 8'h00 || seg_l !== 8'h00) begin
      fails++;
      $display("FAIL async_reset_segs: seg_sel=%h seg_r=%h seg_l=%h, required 00 00 00", seg_sel, seg_r, seg_l);
    end
    tests++;
    if (frame_ready !== 1'b1 || frame_start !== 1'b0) begin
      fails++;
      $display("FAIL async_reset_ctrl: frame_ready=%b frame_start=%b, required 1 0", frame_ready, frame_start);
    end
    step();
    rst_n = 1'b1;
    wait_frame_start(4);
    tests++;
    if (frame_ready !== 1'b1) begin fails++; $display("FAIL ready_after_reset: got %b, required 1", frame_ready); end
    disp     = '0;
    queued_v = 1'b0;
    fnum     = 0;
    run_frame(-1, '0, 1'b0, '0);
    run_frame(-1, '0, 1'b0, '0);
  endtask

  initial begin
    rst_n       = 1'b1;
    enable      = 1'b0;
    frame_data  = '0;
    frame_valid = 1'b0;
    brightness  = 4'd15;
    blink_mask  = 8'h00;
    #1;
    rst_n = 1'b0;
    test_reset();
    test_scan();
    test_update();
    test_back_to_back();
    test_blink();
    test_enable();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
